// File: rtl/booth_control_unit.sv
// booth_control_unit: Moore sequencer issuing c0-c6 strobes for a 64-iteration radix-2 Booth multiplier
module booth_control_unit (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic q0,
  input  logic q_m1,
  input  logic count63,
  output logic c0,
  output logic c1,
  output logic c2,
  output logic c3,
  output logic c4,
  output logic c5,
  output logic c6,
  output logic busy,
  output logic done
);
  typedef enum logic [3:0] {IDLE, INIT, TEST, ADD, SUB, SHIFT, OUT_HI, OUT_LO, DONE} state_t;
  state_t state_q, state_d;
  logic [8:0] out_q, out_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? INIT : IDLE;
      INIT:    state_d = TEST;
      TEST:    state_d = (q0 & ~q_m1) ? SUB : (~q0 & q_m1) ? ADD : SHIFT;
      ADD:     state_d = SHIFT;
      SUB:     state_d = SHIFT;
      SHIFT:   state_d = count63 ? OUT_HI : TEST;
      OUT_HI:  state_d = OUT_LO;
      OUT_LO:  state_d = DONE;
      default: state_d = IDLE;
    endcase
    out_d = {state_d == INIT, state_d == ADD, state_d == SUB, state_d == SHIFT, state_d == SHIFT,
             state_d == OUT_HI, state_d == OUT_LO, state_d != IDLE, state_d == DONE};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end
  assign {c0, c1, c2, c3, c4, c5, c6, busy, done} = out_q;
endmodule

// File: tb/tb_booth_control_unit.sv
// tb_booth_control_unit: scoreboard bench with a counter/Q-register environment model
module tb_booth_control_unit;
  logic clk = 1'b0;
  logic rst, start, frc;
  logic c0, c1, c2, c3, c4, c5, c6, busy, done;
  logic [63:0] qreg, mult_cur;
  logic qm1;
  logic [6:0] cnt;
  logic [8:0] sb[$];
  int compared = 0;
  int mismatched = 0;
  localparam logic [8:0] V_INIT = 9'b100000010, V_TEST = 9'b000000010, V_ADD = 9'b010000010,
                         V_SUB = 9'b001000010, V_SHIFT = 9'b000110010, V_OHI = 9'b000001010,
                         V_OLO = 9'b000000110, V_DONE = 9'b000000011, V_IDLE = 9'b000000000;
  wire [8:0] obs = {c0, c1, c2, c3, c4, c5, c6, busy, done};
  always #5 clk = ~clk;
  booth_control_unit dut (
    .clk(clk), .rst(rst), .start(start), .q0(qreg[0]), .q_m1(qm1), .count63((cnt == 7'd63) | frc),
    .c0(c0), .c1(c1), .c2(c2), .c3(c3), .c4(c4), .c5(c5), .c6(c6), .busy(busy), .done(done)
  );
  always @(posedge clk) begin
    if (c0) begin
      cnt  <= '0;
      qreg <= mult_cur;
      qm1  <= 1'b0;
    end else begin
      if (c4) cnt <= cnt + 7'd1;
      if (c3) begin
        qm1  <= qreg[0];
        qreg <= {1'b0, qreg[63:1]};
      end
    end
  end
  task automatic chk(input logic [8:0] exp, input string tag, input int idx);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s idx=%0d observed=%b expected=%b", tag, idx, obs, exp);
    end
  endtask
  task automatic push_seq(input logic [63:0] m, input int iters);
    logic prev;
    prev = 1'b0;
    sb.push_back(V_INIT);
    for (int i = 0; i < iters; i++) begin
      sb.push_back(V_TEST);
      if (m[i] && !prev) sb.push_back(V_SUB);
      if (!m[i] && prev) sb.push_back(V_ADD);
      sb.push_back(V_SHIFT);
      prev = m[i];
    end
    sb.push_back(V_OHI);
    sb.push_back(V_OLO);
    sb.push_back(V_DONE);
    sb.push_back(V_IDLE);
  endtask
  task automatic run_op(input logic [63:0] m, input int iters, input int flo, input int fhi,
                        input bit pulse, input int stop_at, input string tag);
    int idx, total;
    mult_cur = m;
    push_seq(m, iters);
    total = sb.size();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idx = 0;
    while (sb.size() > 0) begin
      chk(sb.pop_front(), tag, idx);
      if (idx == stop_at) begin
        rst = 1'b1;
        sb.delete();
      end
      frc = (idx >= flo) && (idx <= fhi);
      start = pulse && (idx % 2 == 0) && (idx + 4 < total);
      idx++;
      @(negedge clk);
    end
    start = 1'b0;
    frc = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    start = 1'b1;
    frc = 1'b0;
    mult_cur = '0;
    repeat (2) begin
      @(negedge clk);
      chk(V_IDLE, "reset", 0);
    end
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk(V_IDLE, "idle", 0);
    run_op(64'h0, 64, -1, -1, 1'b0, -1, "zero");
    run_op(64'h5555_5555_5555_5555, 64, -1, -1, 1'b0, -1, "alt");
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64, -1, -1, 1'b0, -1, "ones");
    run_op(64'hA5C3_0F96_1234_8001, 64, -1, -1, 1'b1, -1, "pulse");
    run_op(64'h0, 64, -1, -1, 1'b0, 20, "rst_mid");
    chk(V_IDLE, "rst_mid_idle", 0);
    rst = 1'b0;
    run_op(64'h8000_0000_0000_0001, 64, -1, -1, 1'b0, -1, "after_rst");
    run_op(64'h5555_5555_5555_5555, 64, 13, 14, 1'b0, -1, "frc_test");
    run_op(64'h0, 3, 6, 6, 1'b0, -1, "frc_shift");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
